ddr_rd_calib: RTL and testbench
===============================

Name: ddr_rd_calib

Overview:
- Multi-lane read-capture calibration engine for the DDR3 PHY. Runs in the PCLK domain, beside the gw2a_ddr_iob instances.
- For each byte lane it sweeps the IOB capture SHIFT setting and checks the deserialised read data against a known training pattern.
- It then locks each lane to the centre of the first passing window.
- Generalises the fixed per-instance SHIFT of the IOB to LANES lanes, a parametrised shift depth, settle time, match length and timeout.

Parameters:
- LANES, 2, number of byte lanes calibrated in parallel.
- LBITS, 16, read-data bits per lane per clock (8 DQ x 2 phases).
- SHIFTS, 4, number of capture shift settings swept (0..SHIFTS-1).
- SBITS, 2, width of each shift code; must satisfy 2**SBITS >= SHIFTS.
- SETTLE, 4, cycles waited after each shift change before checking (covers IOB pipeline latency).
- MATCH, 8, consecutive matching valid words required for a shift to pass.
- TIMEOUT, 32, maximum cycles in CHECK before the shift is declared failed.
- PATTERN, 16'hA55A, expected per-lane word during training.

Ports:
- clock, input, 1, PCLK-domain clock.
- reset_n, input, 1, asynchronous active-low reset.
- cal_start_i, input, 1, single-cycle start pulse; ignored while busy.
- cal_busy_o, output, 1, high from the cycle after an accepted start until done.
- cal_done_o, output, 1, high once every lane is in LOCK or FAIL; held until the next start.
- cal_fail_o, output, 1, OR of all lane FAIL states; valid when cal_done_o=1.
- lane_lock_o, output, LANES, per-lane lock flags.
- shift_o, output, LANES*SBITS, per-lane shift code driven to the IOB SHIFT inputs; lane n occupies [n*SBITS +: SBITS].
- rd_valid_i, input, 1, read-data valid strobe from the capture path.
- rd_data_i, input, LANES*LBITS, captured read data; lane n occupies [n*LBITS +: LBITS].

Behaviour:
- Reset (asynchronous, reset_n=0): all lane FSMs go to IDLE. shift_o=0, lane_lock_o=0, cal_busy_o=0, cal_done_o=0, cal_fail_o=0, and all counters and window registers clear. This applies mid-calibration too, with no partial result retained.
- Start: cal_start_i=1 while not busy is accepted.
  - Next cycle: cal_busy_o=1; done, fail and lock flags clear; every lane enters SETTLE with shift_o=0.
  - A start while busy is ignored.
  - A start after done reruns the full calibration.
- Per-lane FSM (all lanes run independently, in lockstep from start):
  - IDLE: wait for an accepted start.
  - SETTLE: count SETTLE cycles; rd_valid_i is ignored. Then go to CHECK with the match and timeout counters cleared.
  - CHECK, on each rd_valid_i cycle:
    - Lane word == PATTERN: increment the match counter. Reaching MATCH marks the shift as pass and goes to NEXT.
    - Lane word != PATTERN: mark the shift as fail and go to NEXT.
  - CHECK, timeout: the counter increments every cycle. Reaching TIMEOUT before a pass/fail decision marks the shift as fail and goes to NEXT. A decision in the same cycle as the timeout takes priority over the timeout.
  - NEXT (one cycle):
    - Pass with no run open: first=last=shift, open the run.
    - Pass with a run open: last=shift.
    - Fail with a run open: close the run and finish.
    - Finish if the run is closed or shift==SHIFTS-1. Otherwise shift_o lane += 1 and return to SETTLE.
  - On finish:
    - A run was recorded: shift_o lane = (first+last)>>1 (floor), go to LOCK, lane_lock_o=1.
    - No run was recorded: shift_o lane = 0, go to FAIL.
  - LOCK and FAIL are held until reset or the next accepted start.
- Done: cal_done_o rises, and cal_busy_o falls, on the first cycle in which all lanes are in LOCK or FAIL. cal_fail_o is set in the same cycle.
- The sweep never wraps: shift SHIFTS-1 is the last one tried.
- shift_o changes only on NEXT or finish transitions, so it is stable during SETTLE and CHECK.

Test Plan:
- Defaults. Lane0 data matches PATTERN only at shifts 1 and 2; lane1 only at shift 3 → lane0 shift_o=1, lane1 shift_o=3, lane_lock_o=2'b11, cal_done_o=1, cal_fail_o=0.
- Lane1 never matches → lane1 goes to FAIL with shift_o=0, lane_lock_o=2'b01, cal_fail_o=1, cal_done_o=1. Lane0 locks normally.
- rd_valid_i held low → each shift times out after 32 cycles; both lanes FAIL. Done arrives at 4 × (4 SETTLE + 32 CHECK + 1 NEXT) + 1 cycles after start.
- Lane0 passes at shifts 0 and 1, fails at 2, passes at 3 → sweep stops after shift 2, shift_o=0, locked. Shift 3 is never applied.
- A single mismatch on the 7th valid word at shift 0 → shift 0 fails. Also: cal_start_i pulsed while busy → no effect.
- reset_n driven low during CHECK → all outputs go to 0 immediately. After release, a new start completes a full calibration.

Source files
------------

// File: rtl/ddr_rd_calib.sv
// Per-lane read-capture calibration: sweeps the IOB SHIFT code, checks each
// setting against a training pattern and locks to the centre of the first passing window.
module ddr_rd_calib #(
  parameter int               LANES   = 2,
  parameter int               LBITS   = 16,
  parameter int               SHIFTS  = 4,
  parameter int               SBITS   = 2,
  parameter int               SETTLE  = 4,
  parameter int               MATCH   = 8,
  parameter int               TIMEOUT = 32,
  parameter logic [LBITS-1:0] PATTERN = 16'hA55A
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     cal_start_i,
  output logic                     cal_busy_o,
  output logic                     cal_done_o,
  output logic                     cal_fail_o,
  output logic [LANES-1:0]         lane_lock_o,
  output logic [LANES*SBITS-1:0]   shift_o,
  input  logic                     rd_valid_i,
  input  logic [LANES*LBITS-1:0]   rd_data_i
);

  localparam int SCW = $clog2(SETTLE + 1);
  localparam int MCW = $clog2(MATCH + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  localparam logic [SCW-1:0]   SETTLE_LAST = SCW'(SETTLE - 1);
  localparam logic [MCW-1:0]   MATCH_LAST  = MCW'(MATCH - 1);
  localparam logic [TCW-1:0]   TO_LAST     = TCW'(TIMEOUT - 1);
  localparam logic [SBITS-1:0] SHIFT_LAST  = SBITS'(SHIFTS - 1);
  localparam logic [SCW-1:0]   S_ONE       = SCW'(1);
  localparam logic [MCW-1:0]   M_ONE       = MCW'(1);
  localparam logic [TCW-1:0]   T_ONE       = TCW'(1);
  localparam logic [SBITS-1:0] SH_ONE      = SBITS'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_CHECK  = 3'd2,
    S_NEXT   = 3'd3,
    S_LOCK   = 3'd4,
    S_FAIL   = 3'd5
  } lane_state_t;

  logic                   r_busy;
  logic                   r_done;
  logic                   r_fail;
  logic                   w_start;
  logic [LANES-1:0]       w_term;
  logic [LANES-1:0]       w_lfail;
  logic [LANES-1:0]       w_lock;
  logic [LANES*SBITS-1:0] w_shift;

  assign w_start = cal_start_i & ~r_busy;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_state_t      r_state;
    logic [SBITS-1:0] r_shift;
    logic [SBITS-1:0] r_first;
    logic [SBITS-1:0] r_last;
    logic             r_open;
    logic             r_pass;
    logic             r_lock;
    logic [SCW-1:0]   r_scnt;
    logic [MCW-1:0]   r_mcnt;
    logic [TCW-1:0]   r_tcnt;

    logic             w_hit;
    logic             w_close;
    logic             w_finish;
    logic             w_rec;
    logic [SBITS-1:0] w_first_n;
    logic [SBITS-1:0] w_last_n;
    logic [SBITS:0]   w_sum;
    logic [SBITS-1:0] w_centre;

    assign w_hit = (rd_data_i[g*LBITS +: LBITS] == PATTERN);

    // Window bookkeeping for the NEXT step; the sum is one bit wider so the centre floors correctly
    always_comb begin
      w_close   = r_open & ~r_pass;
      w_finish  = w_close | (r_shift == SHIFT_LAST);
      w_rec     = r_open | r_pass;
      w_first_n = r_first;
      w_last_n  = r_last;
      if (r_pass) begin
        w_last_n = r_shift;
        if (!r_open) begin
          w_first_n = r_shift;
        end else begin
          w_first_n = r_first;
        end
      end else begin
        w_last_n = r_last;
      end
      w_sum    = {1'b0, w_first_n} + {1'b0, w_last_n};
      w_centre = w_sum[SBITS:1];
    end

    // Lane sweep FSM: a mismatch or a full match run beats a same-cycle timeout
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= S_IDLE;
        r_shift <= '0;
        r_first <= '0;
        r_last  <= '0;
        r_open  <= 1'b0;
        r_pass  <= 1'b0;
        r_lock  <= 1'b0;
        r_scnt  <= '0;
        r_mcnt  <= '0;
        r_tcnt  <= '0;
      end else if (w_start) begin
        r_state <= S_SETTLE;
        r_shift <= '0;
        r_first <= '0;
        r_last  <= '0;
        r_open  <= 1'b0;
        r_pass  <= 1'b0;
        r_lock  <= 1'b0;
        r_scnt  <= '0;
        r_mcnt  <= '0;
        r_tcnt  <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_LOCK, S_FAIL: begin
            r_state <= r_state;
          end
          S_SETTLE: begin
            if (r_scnt == SETTLE_LAST) begin
              r_scnt  <= '0;
              r_mcnt  <= '0;
              r_tcnt  <= '0;
              r_state <= S_CHECK;
            end else begin
              r_scnt <= r_scnt + S_ONE;
            end
          end
          S_CHECK: begin
            if (rd_valid_i && !w_hit) begin
              r_pass  <= 1'b0;
              r_state <= S_NEXT;
            end else if (rd_valid_i && (r_mcnt == MATCH_LAST)) begin
              r_pass  <= 1'b1;
              r_state <= S_NEXT;
            end else if (r_tcnt == TO_LAST) begin
              r_pass  <= 1'b0;
              r_state <= S_NEXT;
            end else begin
              r_tcnt <= r_tcnt + T_ONE;
              if (rd_valid_i) begin
                r_mcnt <= r_mcnt + M_ONE;
              end
            end
          end
          S_NEXT: begin
            r_first <= w_first_n;
            r_last  <= w_last_n;
            r_open  <= w_rec;
            r_scnt  <= '0;
            if (!w_finish) begin
              r_shift <= r_shift + SH_ONE;
              r_state <= S_SETTLE;
            end else if (w_rec) begin
              r_shift <= w_centre;
              r_lock  <= 1'b1;
              r_state <= S_LOCK;
            end else begin
              r_shift <= '0;
              r_state <= S_FAIL;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end

    assign w_term[g]                  = (r_state == S_LOCK) || (r_state == S_FAIL);
    assign w_lfail[g]                 = (r_state == S_FAIL);
    assign w_lock[g]                  = r_lock;
    assign w_shift[g*SBITS +: SBITS]  = r_shift;
  end

  // Global status: done/fail are latched on the first cycle every lane has settled
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_fail <= 1'b0;
    end else if (w_start) begin
      r_busy <= 1'b1;
      r_done <= 1'b0;
      r_fail <= 1'b0;
    end else if (r_busy && (&w_term)) begin
      r_busy <= 1'b0;
      r_done <= 1'b1;
      r_fail <= |w_lfail;
    end else begin
      r_busy <= r_busy;
    end
  end

  assign cal_busy_o  = r_busy;
  assign cal_done_o  = r_done;
  assign cal_fail_o  = r_fail;
  assign lane_lock_o = w_lock;
  assign shift_o     = w_shift;

endmodule

// File: tb/tb_ddr_rd_calib.sv
// Scoreboard bench for ddr_rd_calib: a channel model answers each lane's shift
// setting, expected lock results are queued at start and compared at done.
module tb_ddr_rd_calib;

  localparam logic [15:0] PAT = 16'hA55A;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cal_start_i;
  logic        cal_busy_o;
  logic        cal_done_o;
  logic        cal_fail_o;
  logic [1:0]  lane_lock_o;
  logic [3:0]  shift_o;
  logic        rd_valid_i;
  logic [31:0] rd_data_i;

  ddr_rd_calib dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cal_start_i (cal_start_i),
    .cal_busy_o  (cal_busy_o),
    .cal_done_o  (cal_done_o),
    .cal_fail_o  (cal_fail_o),
    .lane_lock_o (lane_lock_o),
    .shift_o     (shift_o),
    .rd_valid_i  (rd_valid_i),
    .rd_data_i   (rd_data_i)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] lock;
    logic [3:0] shifts;
    logic       fail;
    int         lat;
  } exp_t;

  exp_t sb_q[$];

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [3:0] mask [2];
  int         valid_mode;
  int         inj_cyc;
  int         inj_lane;
  int         pulse_cyc;
  int         cyc;
  int         max_shift0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference answer for one lane: centre of the first contiguous run of passing shifts
  function automatic logic [2:0] lane_exp(input logic [3:0] m);
    int  first = 0;
    int  last  = 0;
    bit  open  = 1'b0;
    int  c;
    for (int s = 0; s < 4; s++) begin
      if (m[s]) begin
        if (!open) first = s;
        last = s;
        open = 1'b1;
      end else if (open) begin
        break;
      end
    end
    c = (first + last) / 2;
    if (open) return {1'b1, c[1:0]};
    return 3'b000;
  endfunction

  task automatic drive();
    logic [1:0]  sh;
    logic [15:0] w;
    logic        v;
    case (valid_mode)
      0:       v = 1'b1;
      1:       v = 1'b0;
      default: v = ((cyc % 4) != 3);
    endcase
    rd_valid_i = v;
    for (int l = 0; l < 2; l++) begin
      sh = shift_o[l*2 +: 2];
      w  = mask[l][sh] ? PAT : (PAT ^ 16'h0010);
      if ((inj_cyc == cyc) && (inj_lane == l)) w = 16'h5AA5;
      if (!v) w = 16'($urandom);
      rd_data_i[l*16 +: 16] = w;
    end
    if (cal_busy_o && (int'(shift_o[1:0]) > max_shift0)) max_shift0 = int'(shift_o[1:0]);
    cal_start_i = (cyc == pulse_cyc);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    drive();
  endtask

  task automatic start_run(input logic [3:0] em0, input logic [3:0] em1, input int lat);
    exp_t       e;
    logic [2:0] r0;
    logic [2:0] r1;
    r0       = lane_exp(em0);
    r1       = lane_exp(em1);
    e.lock   = {r1[2], r0[2]};
    e.shifts = {r1[1:0], r0[1:0]};
    e.fail   = ~(r0[2] & r1[2]);
    e.lat    = lat;
    sb_q.push_back(e);
    cal_start_i = 1'b1;
    @(posedge clock);
    #1;
    cal_start_i = 1'b0;
    cyc         = 0;
    max_shift0  = 0;
    drive();
    check_val("busy_after_start", {31'd0, cal_busy_o}, 32'd1);
    check_val("flags_cleared", {29'd0, cal_done_o, lane_lock_o}, 32'd0);
  endtask

  task automatic wait_done();
    int   n = 0;
    exp_t e;
    while (!cal_done_o && (n < 1000)) begin
      tick();
      n++;
    end
    if (!cal_done_o) begin
      check_val("done_timeout", {31'd0, cal_done_o}, 32'd1);
    end else begin
      check_val("busy_at_done", {31'd0, cal_busy_o}, 32'd0);
    end
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val("lane_lock", {30'd0, lane_lock_o}, {30'd0, e.lock});
      check_val("shift", {28'd0, shift_o}, {28'd0, e.shifts});
      check_val("cal_fail", {31'd0, cal_fail_o}, {31'd0, e.fail});
      if (e.lat >= 0) check_val("latency", n, e.lat);
    end
    pulse_cyc = -1;
    inj_cyc   = -1;
    tick();
    tick();
    check_val("done_held", {31'd0, cal_done_o}, 32'd1);
  endtask

  initial begin
    reset_n     = 1'b0;
    cal_start_i = 1'b0;
    rd_valid_i  = 1'b0;
    rd_data_i   = 32'd0;
    valid_mode  = 0;
    inj_cyc     = -1;
    inj_lane    = 0;
    pulse_cyc   = -1;
    cyc         = 0;
    max_shift0  = 0;
    mask[0]     = 4'b0110;
    mask[1]     = 4'b1000;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_busy", {31'd0, cal_busy_o}, 32'd0);
    check_val("rst_done", {31'd0, cal_done_o}, 32'd0);
    check_val("rst_fail", {31'd0, cal_fail_o}, 32'd0);
    check_val("rst_lock", {30'd0, lane_lock_o}, 32'd0);
    check_val("rst_shift", {28'd0, shift_o}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // default windows with gaps in the valid strobe
    valid_mode = 2;
    mask[0] = 4'b0110; mask[1] = 4'b1000;
    start_run(4'b0110, 4'b1000, -1);
    wait_done();

    // lane1 never matches
    valid_mode = 0;
    mask[0] = 4'b0110; mask[1] = 4'b0000;
    start_run(4'b0110, 4'b0000, -1);
    wait_done();

    // no valid data at all: every shift times out
    valid_mode = 1;
    start_run(4'b0000, 4'b0000, 149);
    wait_done();

    // lane0 window closes at shift 2, shift 3 must never be applied
    valid_mode = 2;
    mask[0] = 4'b1011; mask[1] = 4'b0100;
    start_run(4'b1011, 4'b0100, -1);
    wait_done();
    check_val("max_shift_lane0", max_shift0, 2);

    // 7th valid word of shift 0 corrupted, plus a start pulse while busy
    valid_mode = 0;
    mask[0] = 4'b0011; mask[1] = 4'b1000;
    inj_lane  = 0;
    inj_cyc   = 10;
    pulse_cyc = 20;
    start_run(4'b0010, 4'b1000, 32);
    wait_done();

    // asynchronous reset during CHECK, then a full rerun
    valid_mode = 0;
    mask[0] = 4'b0110; mask[1] = 4'b1000;
    start_run(4'b0110, 4'b1000, -1);
    while (cyc < 30) tick();
    #2;
    reset_n = 1'b0;
    #1;
    sb_q.delete();
    check_val("mid_rst_busy", {31'd0, cal_busy_o}, 32'd0);
    check_val("mid_rst_shift", {28'd0, shift_o}, 32'd0);
    check_val("mid_rst_lock", {29'd0, cal_done_o, lane_lock_o}, 32'd0);
    #3;
    reset_n = 1'b1;
    tick();
    start_run(4'b0110, 4'b1000, -1);
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
